// File: rtl/pad_cond_pkg.sv
// Shared constants for pad conditioning: default block parameters and
// the per-side bit slices of the 36-pad padring mapping.
package pad_cond_pkg;

    localparam int PadNumGpio    = 32;
    localparam int PadSyncStages = 2;
    localparam int PadDebounceW  = 4;

    // Per-side slices (low/high bit) of the 36-pad padring bus
    localparam int PadWeLo = 0;
    localparam int PadWeHi = 8;
    localparam int PadNoLo = 9;
    localparam int PadNoHi = 17;
    localparam int PadEaLo = 18;
    localparam int PadEaHi = 26;
    localparam int PadSoLo = 27;
    localparam int PadSoHi = 35;

endpackage

// File: rtl/pad_debounce_bit.sv
// One pad input bit: synchroniser, debounce filter and edge detect.
// Ports: clk_i/rst_i, i_pad (async pad data), i_thresh (debounce T),
//        i_bypass (skip filter), o_level (filtered), o_rise/o_fall pulses.
module pad_debounce_bit
    import pad_cond_pkg::*;
#(
    parameter int SyncStages = PadSyncStages,
    parameter int DebounceW  = PadDebounceW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_pad,
    input  logic [DebounceW-1:0] i_thresh,
    input  logic                 i_bypass,
    output logic                 o_level,
    output logic                 o_rise,
    output logic                 o_fall
);

    logic [SyncStages-1:0] r_sync;
    logic [DebounceW-1:0]  r_cnt;
    logic                  r_q;
    logic                  r_q_d;
    logic                  w_s;

    assign w_s = r_sync[SyncStages-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], i_pad};
        end
    end

    // cnt never exceeds T: it is cleared whenever it reaches T and a
    // differing sample arrives, so the increment cannot wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q   <= 1'b0;
            r_q_d <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_q_d <= r_q;
            if (i_bypass) begin
                r_q   <= w_s;
                r_cnt <= '0;
            end else if (w_s == r_q) begin
                r_cnt <= '0;
            end else if (r_cnt >= i_thresh) begin
                r_q   <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DebounceW'(1);
            end
        end
    end

    assign o_level = r_q;
    assign o_rise  = r_q & ~r_q_d;
    assign o_fall  = ~r_q & r_q_d;

endmodule

// File: rtl/pad_gpio_cond.sv
// Pad-side GPIO conditioning: filtered inputs with edge events and irq,
// registered pad outputs. Ports: pad_din_i -> gpio_o/rise_o/fall_o,
// evt_* sticky pending + irq_o, gpio_out_i/gpio_en_i -> pad_dout/oen/ie.
module pad_gpio_cond
    import pad_cond_pkg::*;
#(
    parameter int NumGpio    = PadNumGpio,
    parameter int SyncStages = PadSyncStages,
    parameter int DebounceW  = PadDebounceW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumGpio-1:0]   pad_din_i,
    output logic [NumGpio-1:0]   gpio_o,
    input  logic [DebounceW-1:0] db_thresh_i,
    input  logic [NumGpio-1:0]   db_bypass_i,
    output logic [NumGpio-1:0]   rise_o,
    output logic [NumGpio-1:0]   fall_o,
    input  logic [NumGpio-1:0]   evt_mask_i,
    input  logic [NumGpio-1:0]   evt_clear_i,
    output logic [NumGpio-1:0]   evt_pending_o,
    output logic                 irq_o,
    input  logic [NumGpio-1:0]   gpio_out_i,
    input  logic [NumGpio-1:0]   gpio_en_i,
    output logic [NumGpio-1:0]   pad_dout_o,
    output logic [NumGpio-1:0]   pad_oen_o,
    output logic [NumGpio-1:0]   pad_ie_o
);

    logic [NumGpio-1:0] w_level;
    logic [NumGpio-1:0] w_rise;
    logic [NumGpio-1:0] w_fall;
    logic [NumGpio-1:0] w_set;
    logic [NumGpio-1:0] r_pend;
    logic [NumGpio-1:0] r_dout;
    logic [NumGpio-1:0] r_oen;

    for (genvar g = 0; g < NumGpio; g++) begin : g_bit
        pad_debounce_bit #(
            .SyncStages (SyncStages),
            .DebounceW  (DebounceW)
        ) u_bit (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .i_pad    (pad_din_i[g]),
            .i_thresh (db_thresh_i),
            .i_bypass (db_bypass_i[g]),
            .o_level  (w_level[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign w_set = (w_rise | w_fall) & evt_mask_i;

    // Set is OR'd after the clear so a same-cycle event wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~evt_clear_i) | w_set;
        end
    end

    // Reset leaves pads tristated with input buffers enabled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dout <= '0;
            r_oen  <= '1;
        end else begin
            r_dout <= gpio_out_i;
            r_oen  <= ~gpio_en_i;
        end
    end

    assign gpio_o        = w_level;
    assign rise_o        = w_rise;
    assign fall_o        = w_fall;
    assign evt_pending_o = r_pend;
    assign irq_o         = |r_pend;
    assign pad_dout_o    = r_dout;
    assign pad_oen_o     = r_oen;
    assign pad_ie_o      = r_oen;

endmodule
